// File: rtl/v850_pkg.sv
// Shared types, widths and helpers for the v850 instruction fetch stage.
package v850_pkg;

  localparam int PC_W = 26;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } fetch_state_t;

  // Any halfword with bits [10:9] set starts a 32-bit (or unsupported 48-bit) form.
  function automatic logic is_len32(input logic [15:0] hw);
    return (hw[10:9] == 2'b11);
  endfunction

  function automatic logic [31:0] sext_pc(input logic [PC_W-1:0] pc);
    return {{(32-PC_W){pc[PC_W-1]}}, pc};
  endfunction

endpackage

// File: rtl/fetch_hw_queue.sv
// Four-entry halfword FIFO; accepts and releases one or two halfwords per cycle.
module fetch_hw_queue
  import v850_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_flush,
  input  logic [1:0]  i_pushCnt,
  input  logic [15:0] i_pushLo,
  input  logic [15:0] i_pushHi,
  input  logic [1:0]  i_popCnt,
  output logic [2:0]  o_count,
  output logic [15:0] o_head0,
  output logic [15:0] o_head1
);

  logic [15:0] r_mem [4];
  logic [1:0]  r_rdPtr;
  logic [2:0]  r_count;
  logic [1:0]  w_wrPtr;

  assign w_wrPtr = r_rdPtr + r_count[1:0];

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_rdPtr <= 2'd0;
      r_count <= 3'd0;
    end else begin
      r_rdPtr <= r_rdPtr + i_popCnt;
      r_count <= r_count + {1'b0, i_pushCnt} - {1'b0, i_popCnt};
    end
  end

  // Writes land past the old tail, so slots freed by a same-cycle pop may be reused.
  always_ff @(posedge i_clk) begin
    if (!i_rst && !i_flush) begin
      if (i_pushCnt != 2'd0) r_mem[w_wrPtr] <= i_pushLo;
      if (i_pushCnt == 2'd2) r_mem[w_wrPtr + 2'd1] <= i_pushHi;
    end
  end

  assign o_count = r_count;
  assign o_head0 = r_mem[r_rdPtr];
  assign o_head1 = r_mem[r_rdPtr + 2'd1];

endmodule

// File: rtl/v850_fetch.sv
// Fetch stage: word requests to imem, halfword queue, length decode and redirect handling.
module v850_fetch
  import v850_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_word,
  output logic        inst_len32,
  output logic [31:0] inst_pc
);

  fetch_state_t r_state, w_nextState;
  logic [PC_W-1:0] r_headPc, r_fetchAddr;
  logic            r_skipLow;

  logic        w_accept, w_resp, w_deq, w_headLen32, w_instValid;
  logic [1:0]  w_pushCnt, w_popCnt;
  logic [2:0]  w_count;
  logic [15:0] w_head0, w_head1, w_pushLo;
  logic        w_unusedBits;

  assign w_unusedBits = ^redirect_pc[31:PC_W];

  assign w_accept    = imem_req && imem_ready;
  assign w_resp      = (r_state == WAIT) && imem_rvalid && !redirect_valid;
  assign w_headLen32 = is_len32(w_head0);
  assign w_instValid = (w_count >= 3'd2) || ((w_count == 3'd1) && !w_headLen32);
  assign w_deq       = w_instValid && inst_ready && !redirect_valid;
  assign w_popCnt    = !w_deq ? 2'd0 : (w_headLen32 ? 2'd2 : 2'd1);
  assign w_pushCnt   = !w_resp ? 2'd0 : (r_skipLow ? 2'd1 : 2'd2);
  assign w_pushLo    = r_skipLow ? imem_rdata[31:16] : imem_rdata[15:0];

  fetch_hw_queue u_queue (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_flush   (redirect_valid),
    .i_pushCnt (w_pushCnt),
    .i_pushLo  (w_pushLo),
    .i_pushHi  (imem_rdata[31:16]),
    .i_popCnt  (w_popCnt),
    .o_count   (w_count),
    .o_head0   (w_head0),
    .o_head1   (w_head1)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  // A response arriving alongside a redirect still retires the request, so no DROP is needed.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_nextState = WAIT;
      WAIT:    if (imem_rvalid) w_nextState = IDLE;
               else if (redirect_valid) w_nextState = DROP;
      DROP:    if (imem_rvalid) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    imem_req = !rst && (r_state == IDLE) && (w_count <= 3'd2) && !redirect_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_headPc    <= RESET_VECTOR[PC_W-1:0] & ~(PC_W'(1));
      r_fetchAddr <= RESET_VECTOR[PC_W-1:0] & ~(PC_W'(3));
      r_skipLow   <= RESET_VECTOR[1];
    end else if (redirect_valid) begin
      r_headPc    <= redirect_pc[PC_W-1:0] & ~(PC_W'(1));
      r_fetchAddr <= redirect_pc[PC_W-1:0] & ~(PC_W'(3));
      r_skipLow   <= redirect_pc[1];
    end else begin
      if (w_accept) r_fetchAddr <= r_fetchAddr + PC_W'(4);
      if (w_resp)   r_skipLow   <= 1'b0;
      if (w_deq)    r_headPc    <= r_headPc + (w_headLen32 ? PC_W'(4) : PC_W'(2));
    end
  end

  assign imem_addr  = sext_pc(r_fetchAddr);
  assign inst_pc    = sext_pc(r_headPc);
  assign inst_valid = w_instValid;
  assign inst_len32 = w_instValid && w_headLen32;
  assign inst_word  = !w_instValid ? 32'h0 :
                      (w_headLen32 ? {w_head1, w_head0} : {16'h0, w_head0});

endmodule
